// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types for the RAM-port arbiter: RAM handshake state, arbiter FSM
//   state, and the data-path word width.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    // Encoding matches the RAM model: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2,
        ERR    = 2'd3
    } arbstate_t;

    // Bits needed to hold values 0..max (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Signal bundle between the instruction requester, the data requester, the
//   RAM port and the arbiter.
//   arb modport : arbiter view (requests/RAM status in, stalls/RAM drive out)
//   tb  modport : requester + RAM view (mirror of arb)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // Instruction requester
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    // Data requester
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    // RAM port
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    ramstate_t         ramstate;
    // Status
    logic              err;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/mem_arbiter_timer.sv
// -----------------------------------------------------------------------------
// mem_arbiter_timer (grant timer, arb_timer role)
//   Counts consecutive grant cycles without ACCESS and flags the cycle on which
//   the TIMEOUT-th such cycle is reached.
//   CLK     in  clock, rising edge
//   RST     in  synchronous active-high reset
//   run     in  granted and no ACCESS this cycle; low clears the count
//   expired out run is high and this is the TIMEOUT-th waiting cycle
// -----------------------------------------------------------------------------
module mem_arbiter_timer
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = cnt_width(TIMEOUT - 1);

    logic [CW-1:0] tcount_q, tcount_d;

    always_comb begin
        tcount_d = '0;
        if (run) begin
            tcount_d = tcount_q + CW'(1);
        end
    end

    assign expired = run && (tcount_q == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            tcount_q <= '0;
        end else begin
            tcount_q <= tcount_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one RAM port between instruction fetch and data LW/SW. Data wins
//   unless it has taken MAX_DSTREAK grants in a row while fetch was waiting.
//   A grant lasts until ACCESS, requester abort, RAM ERROR, or TIMEOUT cycles;
//   the last two park the arbiter in a sticky ERR state left only by RST.
//   CLK  in  clock, rising edge
//   RST  in  synchronous active-high reset
//   bus  arb modport of mem_arbiter_if (requests, stalls, RAM port, err)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic           CLK,
    input  logic           RST,
    mem_arbiter_if.arb     bus
);

    localparam int unsigned SW = cnt_width(MAX_DSTREAK);

    arbstate_t     state_q, state_d;
    logic [SW-1:0] dstreak_q, dstreak_d;

    logic d_req, access, ram_err, granted, expired;

    assign d_req   = bus.dREN | bus.dWEN;
    assign access  = (bus.ramstate == ACCESS);
    assign ram_err = (bus.ramstate == ERROR);
    assign granted = (state_q == DGRANT) || (state_q == IGRANT);

    mem_arbiter_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .run     (granted && !access),
        .expired (expired)
    );

    // Next state and data-streak bookkeeping
    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        unique case (state_q)
            IDLE: begin
                if (ram_err) begin
                    state_d = ERR;
                end else if (d_req && !(bus.iREN && dstreak_q == SW'(MAX_DSTREAK))) begin
                    state_d = DGRANT;
                    // Streak only grows while fetch is actually being held off.
                    if (!bus.iREN) begin
                        dstreak_d = '0;
                    end else if (dstreak_q != SW'(MAX_DSTREAK)) begin
                        dstreak_d = dstreak_q + SW'(1);
                    end
                end else if (bus.iREN) begin
                    state_d   = IGRANT;
                    dstreak_d = '0;
                end
            end
            DGRANT: begin
                if (ram_err)     state_d = ERR;
                else if (access) state_d = IDLE;
                else if (!d_req) state_d = IDLE;
                else if (expired) state_d = ERR;
            end
            IGRANT: begin
                if (ram_err)        state_d = ERR;
                else if (access)    state_d = IDLE;
                else if (!bus.iREN) state_d = IDLE;
                else if (expired)   state_d = ERR;
            end
            ERR: state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // Outputs are combinational from the registered state and live inputs
    always_comb begin
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.err      = 1'b0;
        unique case (state_q)
            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.dload    = bus.ramload;
                bus.dwait    = ~access;
            end
            IGRANT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = 1'b1;
                bus.iload   = bus.ramload;
                bus.iwait   = ~access;
            end
            ERR: bus.err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic CLK;
    logic RST;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_DSTREAK (4),
        .TIMEOUT     (64)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        isd;
        logic [31:0] addr;
        logic [31:0] load;
    } txn_t;

    txn_t sb[$];
    logic exp_order[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 later.
    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Pop the oldest expected transaction and compare against the ACCESS cycle.
    task automatic check_txn();
        txn_t t;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        t = sb.pop_front();
        chk("txn_addr", bus.ramaddr, t.addr);
        if (t.isd) begin
            chk("txn_dwait", bus.dwait, 0);
            chk("txn_iwait", bus.iwait, 1);
            chk("txn_dload", bus.dload, t.load);
        end else begin
            chk("txn_iwait", bus.iwait, 0);
            chk("txn_dwait", bus.dwait, 1);
            chk("txn_iload", bus.iload, t.load);
        end
    endtask

    initial begin
        int  gcyc;
        int  grants;
        bit  done;

        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = 32'hFFFF_FFFF;
        bus.ramstate = FREE;
        RST          = 1'b1;

        // Reset state
        next_cyc();
        next_cyc();
        RST = 1'b0;
        settle();
        chk("rst_iwait", bus.iwait, 1);
        chk("rst_dwait", bus.dwait, 1);
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_iload", bus.iload, 0);
        chk("rst_dload", bus.dload, 0);
        chk("rst_err", bus.err, 0);

        // Instruction fetch: 3 BUSY cycles then ACCESS
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h40;
        sb.push_back('{isd: 1'b0, addr: 32'h40, load: 32'h8C22_0004});
        settle();
        chk("t1_idle_ren", bus.ramREN, 0);
        for (int c = 1; c <= 4; c++) begin
            next_cyc();
            bus.ramstate = (c == 4) ? ACCESS : BUSY;
            bus.ramload  = (c == 4) ? 32'h8C22_0004 : 32'h0;
            settle();
            chk("t1_ramREN", bus.ramREN, 1);
            chk("t1_ramaddr", bus.ramaddr, 32'h40);
            if (c < 4) chk("t1_iwait_busy", bus.iwait, 1);
            else       check_txn();
        end
        next_cyc();
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        settle();
        chk("t1_after_ren", bus.ramREN, 0);
        chk("t1_after_iwait", bus.iwait, 1);

        // Simultaneous store and fetch: data first, bubble, then fetch
        bus.iREN   = 1'b1;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h100;
        bus.dstore = 32'hDEAD_BEEF;
        sb.push_back('{isd: 1'b1, addr: 32'h100, load: 32'h5A5A_5A5A});
        sb.push_back('{isd: 1'b0, addr: 32'h40, load: 32'h1234_5678});
        next_cyc();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h5A5A_5A5A;
        settle();
        chk("t2_ramWEN", bus.ramWEN, 1);
        chk("t2_ramREN", bus.ramREN, 0);
        chk("t2_ramstore", bus.ramstore, 32'hDEAD_BEEF);
        check_txn();
        next_cyc();
        bus.dWEN     = 1'b0;
        bus.ramstate = FREE;
        settle();
        chk("t2_bubble_wen", bus.ramWEN, 0);
        chk("t2_bubble_ren", bus.ramREN, 0);
        chk("t2_bubble_iwait", bus.iwait, 1);
        next_cyc();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h1234_5678;
        settle();
        chk("t2_igrant_ren", bus.ramREN, 1);
        chk("t2_igrant_store", bus.ramstore, 0);
        check_txn();
        next_cyc();
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        settle();
        chk("t2_after_ren", bus.ramREN, 0);

        // Starvation guard: D,D,D,D,I,D with both requests held
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.dREN  = 1'b1;
        bus.daddr = 32'h200;
        bus.iREN  = 1'b1;
        grants    = 0;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            next_cyc();
            bus.ramstate = FREE;
            settle();
            if (bus.ramREN) begin
                bus.ramstate = ACCESS;
                settle();
                chk("t3_order_isd", bus.ramaddr == 32'h200, exp_order.pop_front());
                grants++;
            end
        end
        chk("t3_grant_count", grants, 6);
        next_cyc();
        bus.dREN     = 1'b0;
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        settle();
        chk("t3_after_ren", bus.ramREN, 0);

        // Timeout: fetch with RAM stuck BUSY
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h40;
        bus.ramstate = BUSY;
        gcyc         = 0;
        done         = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            next_cyc();
            settle();
            if (bus.err) done = 1'b1;
            else if (bus.ramREN) gcyc++;
        end
        chk("t4_grant_cycles", gcyc, 64);
        chk("t4_err", bus.err, 1);
        chk("t4_ren", bus.ramREN, 0);
        chk("t4_iwait", bus.iwait, 1);
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        for (int c = 0; c < 3; c++) begin
            next_cyc();
            settle();
            chk("t4_err_sticky", bus.err, 1);
        end
        RST = 1'b1;
        next_cyc();
        RST = 1'b0;
        settle();
        chk("t4_rst_err", bus.err, 0);

        // RAM ERROR during a data grant
        bus.dREN  = 1'b1;
        bus.daddr = 32'h300;
        next_cyc();
        bus.ramstate = ERROR;
        settle();
        chk("t5_grant_ren", bus.ramREN, 1);
        chk("t5_err_pre", bus.err, 0);
        next_cyc();
        bus.dREN     = 1'b0;
        bus.ramstate = FREE;
        settle();
        chk("t5_err", bus.err, 1);
        chk("t5_dwait", bus.dwait, 1);
        chk("t5_ren", bus.ramREN, 0);
        RST = 1'b1;
        next_cyc();
        RST = 1'b0;
        settle();
        chk("t5_rst_err", bus.err, 0);
        chk("t5_rst_iwait", bus.iwait, 1);
        chk("t5_rst_dwait", bus.dwait, 1);

        // Abort: data drops its request mid-grant, pending fetch follows
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h300;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h80;
        bus.ramstate = BUSY;
        next_cyc();
        settle();
        chk("t6_d1_ren", bus.ramREN, 1);
        chk("t6_d1_addr", bus.ramaddr, 32'h300);
        next_cyc();
        settle();
        chk("t6_d2_ren", bus.ramREN, 1);
        next_cyc();
        bus.dREN = 1'b0;
        settle();
        chk("t6_abort_ren", bus.ramREN, 0);
        chk("t6_abort_dwait", bus.dwait, 1);
        next_cyc();
        settle();
        chk("t6_idle_ren", bus.ramREN, 0);
        chk("t6_idle_iwait", bus.iwait, 1);
        next_cyc();
        settle();
        chk("t6_igrant_ren", bus.ramREN, 1);
        chk("t6_igrant_addr", bus.ramaddr, 32'h80);

        // Reset mid-transaction drops enables after the edge
        RST = 1'b1;
        next_cyc();
        settle();
        chk("t7_rst_ren", bus.ramREN, 0);
        chk("t7_rst_iwait", bus.iwait, 1);
        RST      = 1'b0;
        bus.iREN = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
